// File: rtl/vga_timing_pattern_pkg.sv
// Shared types for the VGA timing/pattern slice: pixel type, pattern mode
// encoding and the eight colour-bar constants.
package vga_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    MODE_GRID  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_EXT   = 2'd3
  } vga_mode_e;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_pattern_if.sv
// Panel-side video bus: syncs, BLANK (1 = active video), coordinates,
// pixel and frame/line pulses. The timing generator drives the master side.
interface video_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import vga_pkg::*;

  logic          hs;
  logic          vs;
  logic          blank;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  rgb_t          rgb;
  logic          line_start;
  logic          frame_start;

  modport master (
    output hs, vs, blank, x, y, rgb, line_start, frame_start
  );

  modport slave (
    input hs, vs, blank, x, y, rgb, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_pattern_sync_counter.sv
// Horizontal/vertical counters and the combinational stage-0 decode
// (syncs, active region, active coordinates, line/frame flags).
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      hs,
  output logic                      vs,
  output logic                      active,
  output logic [$clog2(HDISP)-1:0]  req_x,
  output logic [$clog2(VDISP)-1:0]  req_y,
  output logic                      line_flag,
  output logic                      frame_flag
);

  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);
  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT_S  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT_S  = VW'(VFP + VPULSE + VBP);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last, hs_on, vs_on;

  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    hs_on      = (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
    vs_on      = (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
    hs         = SYNC_POL ? hs_on : ~hs_on;
    vs         = SYNC_POL ? vs_on : ~vs_on;
    active     = (h_cnt_q >= H_ACT_S) && (v_cnt_q >= V_ACT_S);
    req_x      = active ? XW'(h_cnt_q - H_ACT_S) : '0;
    req_y      = active ? YW'(v_cnt_q - V_ACT_S) : '0;
    line_flag  = (h_cnt_q == '0);
    frame_flag = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_timing_pattern.sv
// Parametrised VGA timing generator with test-pattern source; define
// VGA_PATTERN_EN for grid/bars/solid modes, otherwise ext_rgb is always forwarded.
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int HFP       = 40,
  parameter int HPULSE    = 48,
  parameter int HBP       = 40,
  parameter int VFP       = 13,
  parameter int VPULSE    = 3,
  parameter int VBP       = 29,
  parameter bit SYNC_POL  = 1'b0,
  parameter int GRID_LOG2 = 4
) (
  input  logic                      pixel_clk,
  input  logic                      pixel_rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  rgb_t                      solid_rgb,
  input  rgb_t                      ext_rgb,
  output logic                      pix_req,
  output logic [$clog2(HDISP)-1:0]  req_x,
  output logic [$clog2(VDISP)-1:0]  req_y,
  video_if.master                   vout
);

  localparam int   XW        = $clog2(HDISP);
  localparam int   YW        = $clog2(VDISP);
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic s_hs, s_vs, s_active, s_line, s_frame;

  vga_sync_counter #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .HFP      (HFP),
    .HPULSE   (HPULSE),
    .HBP      (HBP),
    .VFP      (VFP),
    .VPULSE   (VPULSE),
    .VBP      (VBP),
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .clk        (pixel_clk),
    .rst_n      (pixel_rst_n),
    .enable     (enable),
    .hs         (s_hs),
    .vs         (s_vs),
    .active     (s_active),
    .req_x      (req_x),
    .req_y      (req_y),
    .line_flag  (s_line),
    .frame_flag (s_frame)
  );

  assign pix_req = s_active;

  rgb_t pat_rgb;

`ifdef VGA_PATTERN_EN
  localparam int BAR_W = HDISP / 8;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  vga_mode_e      mode_q, mode_d;
  rgb_t           solid_q, solid_d;
  logic [BPW-1:0] bar_pos_q, bar_pos_d, cur_pos;
  logic [2:0]     bar_idx_q, bar_idx_d, cur_idx;
  logic           first_px;

  // Bar state is held for the pixel after the current one; the first active
  // pixel of a line substitutes the cleared state so no extra cycle is needed.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (enable && s_frame) begin
      mode_d  = vga_mode_e'(mode);
      solid_d = solid_rgb;
    end

    first_px  = s_active && (req_x == '0);
    cur_pos   = first_px ? '0 : bar_pos_q;
    cur_idx   = first_px ? '0 : bar_idx_q;
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (s_active) begin
      if (cur_pos == BAR_LAST) begin
        bar_pos_d = '0;
        bar_idx_d = (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
      end else begin
        bar_pos_d = cur_pos + BPW'(1);
        bar_idx_d = cur_idx;
      end
    end

    unique case (mode_q)
      MODE_GRID:  pat_rgb = (&req_x[GRID_LOG2-1:0] || &req_y[GRID_LOG2-1:0])
                            ? BAR_WHITE : BAR_BLACK;
      MODE_BARS:  pat_rgb = bar_colour(cur_idx);
      MODE_SOLID: pat_rgb = solid_q;
      default:    pat_rgb = ext_rgb;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      mode_q    <= MODE_GRID;
      solid_q   <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else begin
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
    end
  end
`else
  logic unused_cfg;

  always_comb begin
    pat_rgb    = ext_rgb;
    unused_cfg = ^{mode, solid_rgb};
  end
`endif

  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  rgb_t          rgb_q, rgb_d;

  always_comb begin
    hs_d          = SYNC_IDLE;
    vs_d          = SYNC_IDLE;
    blank_d       = 1'b0;
    x_d           = '0;
    y_d           = '0;
    rgb_d         = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      hs_d          = s_hs;
      vs_d          = s_vs;
      blank_d       = s_active;
      x_d           = req_x;
      y_d           = req_y;
      rgb_d         = s_active ? pat_rgb : '0;
      line_start_d  = s_line;
      frame_start_d = s_frame;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      blank_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vout.hs          = hs_q;
  assign vout.vs          = vs_q;
  assign vout.blank       = blank_q;
  assign vout.x           = x_q;
  assign vout.y           = y_q;
  assign vout.rgb         = rgb_q;
  assign vout.line_start  = line_start_q;
  assign vout.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Directed bench for vga_timing_pattern on a small 64x20 panel so whole
// frames (79 x 27 = 2133 cycles) can be walked cycle by cycle.
module tb_vga_timing_pattern;

  localparam int HDISP = 64, VDISP = 20;
  localparam int HFP = 4, HPULSE = 6, HBP = 5;
  localparam int VFP = 2, VPULSE = 3, VBP = 2;
  localparam int HTOT = 79, VTOT = 27, FRAME = 2133;
  localparam int HACT = 15, VACT = 7;
  localparam logic [23:0] SOLID = 24'h123456;
`ifdef VGA_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] ext_rgb;
  logic        pix_req;
  logic [5:0]  req_x;
  logic [4:0]  req_y;

  int n_chk = 0;
  int n_bad = 0;

  video_if #(.XW(6), .YW(5)) vout ();

  vga_timing_pattern #(
    .HDISP(HDISP), .VDISP(VDISP),
    .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
    .SYNC_POL(1'b0), .GRID_LOG2(4)
  ) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .enable      (enable),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .ext_rgb     (ext_rgb),
    .pix_req     (pix_req),
    .req_x       (req_x),
    .req_y       (req_y),
    .vout        (vout)
  );

  always #5 pixel_clk = ~pixel_clk;

  // External source echoes the requested coordinate.
  always_comb ext_rgb = {3'b000, req_y, 10'b0, req_x};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] mdl(input logic [1:0] md, input int x, input int y);
    logic [23:0] c;
    c = {8'(y), 16'(x)};
    if (PAT) begin
      case (md)
        2'd0: c = ((x % 16 == 15) || (y % 16 == 15)) ? 24'hFFFFFF : 24'h000000;
        2'd1: c = bar_rgb((x / 8 > 7) ? 7 : x / 8);
        2'd2: c = SOLID;
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic point(input string tag, input int px, input int py, input logic [23:0] exp);
    if (vout.blank === 1'b1 && vout.x == 6'(px) && vout.y == 5'(py))
      check_eq(tag, {8'h00, vout.rgb}, {8'h00, exp});
  endtask

  // Precondition: the next rising edge registers counter position (0,0).
  task automatic run_frame(input string name, input logic [1:0] md0,
                           input logic [1:0] md1, input int sw_at);
    int h, v, h1, v1, ex, ey, first_act, fx, fy;
    int hs_err, vs_err, bl_err, xy_err, rgb_err, pl_err, rq_err;
    int hs_low, vs_low, bl_hi, ls_cnt, fs_cnt;
    bit act, act1, e_hs, e_vs;
    hs_err = 0; vs_err = 0; bl_err = 0; xy_err = 0; rgb_err = 0; pl_err = 0; rq_err = 0;
    hs_low = 0; vs_low = 0; bl_hi = 0; ls_cnt = 0; fs_cnt = 0;
    first_act = -1; fx = -1; fy = -1;
    mode = md0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge pixel_clk);
      h = k % HTOT; v = k / HTOT;
      act  = (h >= HACT) && (v >= VACT);
      ex   = act ? h - HACT : 0;
      ey   = act ? v - VACT : 0;
      e_hs = !((h >= HFP) && (h < HFP + HPULSE));
      e_vs = !((v >= VFP) && (v < VFP + VPULSE));
      if (vout.hs !== e_hs) hs_err++;
      if (vout.vs !== e_vs) vs_err++;
      if (vout.blank !== act) bl_err++;
      if (vout.x !== 6'(ex) || vout.y !== 5'(ey)) xy_err++;
      if (vout.rgb !== (act ? mdl(md0, ex, ey) : 24'h0)) rgb_err++;
      if (vout.line_start !== (h == 0) || vout.frame_start !== (k == 0)) pl_err++;
      h1 = ((k + 1) % FRAME) % HTOT; v1 = ((k + 1) % FRAME) / HTOT;
      act1 = (h1 >= HACT) && (v1 >= VACT);
      if (pix_req !== act1 || req_x !== 6'(act1 ? h1 - HACT : 0) ||
          req_y !== 5'(act1 ? v1 - VACT : 0)) rq_err++;
      if (vout.hs === 1'b0) hs_low++;
      if (vout.vs === 1'b0) vs_low++;
      if (vout.blank === 1'b1) bl_hi++;
      if (vout.line_start === 1'b1) ls_cnt++;
      if (vout.frame_start === 1'b1) fs_cnt++;
      if (first_act < 0 && vout.blank === 1'b1) begin
        first_act = k; fx = int'(vout.x); fy = int'(vout.y);
      end
      if (md0 == 2'd0) begin
        point({name, "_grid_x15"},  15, 3,  PAT ? 24'hFFFFFF : 24'h03000F);
        point({name, "_grid_x31"},  31, 3,  PAT ? 24'hFFFFFF : 24'h03001F);
        point({name, "_grid_y15"},  14, 15, PAT ? 24'hFFFFFF : 24'h0F000E);
        point({name, "_grid_off"},  14, 14, PAT ? 24'h000000 : 24'h0E000E);
      end else if (md0 == 2'd1) begin
        point({name, "_bar_x0"},  0,  0,  PAT ? 24'hFFFFFF : 24'h000000);
        point({name, "_bar_x7"},  7,  0,  PAT ? 24'hFFFFFF : 24'h000007);
        point({name, "_bar_x8"},  8,  0,  PAT ? 24'hFFFF00 : 24'h000008);
        point({name, "_bar_x56"}, 56, 0,  PAT ? 24'h000000 : 24'h000038);
        point({name, "_bar_x63"}, 63, 19, PAT ? 24'h000000 : 24'h13003F);
      end else if (md0 == 2'd2) begin
        point({name, "_solid_late"}, 8, 10, PAT ? SOLID : 24'h0A0008);
      end else begin
        point({name, "_ext_00"}, 0,  0,  24'h000000);
        point({name, "_ext_52"}, 5,  2,  24'h020005);
        point({name, "_ext_end"}, 63, 19, 24'h13003F);
      end
      if (k == sw_at) mode = md1;
    end
    check_eq({name, "_hs_seq"},    hs_err,  0);
    check_eq({name, "_vs_seq"},    vs_err,  0);
    check_eq({name, "_blank_seq"}, bl_err,  0);
    check_eq({name, "_xy_seq"},    xy_err,  0);
    check_eq({name, "_rgb_seq"},   rgb_err, 0);
    check_eq({name, "_pulse_seq"}, pl_err,  0);
    check_eq({name, "_req_seq"},   rq_err,  0);
    check_eq({name, "_hs_low"},    hs_low,  162);
    check_eq({name, "_vs_low"},    vs_low,  237);
    check_eq({name, "_blank_hi"},  bl_hi,   1280);
    check_eq({name, "_lines"},     ls_cnt,  27);
    check_eq({name, "_frames"},    fs_cnt,  1);
    check_eq({name, "_first_k"},   first_act, 568);
    check_eq({name, "_first_xy"},  {fx[15:0], fy[15:0]}, 32'h0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_hs"},    vout.hs, 1);
    check_eq({tag, "_vs"},    vout.vs, 1);
    check_eq({tag, "_blank"}, vout.blank, 0);
    check_eq({tag, "_rgb"},   vout.rgb, 0);
    check_eq({tag, "_xy"},    {vout.x, vout.y}, 0);
    check_eq({tag, "_pulse"}, {vout.line_start, vout.frame_start}, 0);
  endtask

  initial begin
    pixel_rst_n = 1'b1;
    enable      = 1'b0;
    mode        = 2'd0;
    solid_rgb   = SOLID;
    #1 pixel_rst_n = 1'b0;
    #11 check_idle("reset");

    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    enable      = 1'b1;
    run_frame("f1_grid", 2'd0, 2'd0, -1);
    run_frame("f2_bars", 2'd1, 2'd1, -1);
    run_frame("f3_sw21", 2'd2, 2'd1, 1000);
    run_frame("f4_bars", 2'd1, 2'd1, -1);
    run_frame("f5_ext",  2'd3, 2'd3, -1);

    for (int i = 0; i < 600; i++) @(negedge pixel_clk);
    check_eq("pre_drop_blank", vout.blank, 1);
    enable = 1'b0;
    @(negedge pixel_clk);
    check_idle("drop");
    for (int i = 0; i < 5; i++) @(negedge pixel_clk);
    check_idle("held");
    enable = 1'b1;
    run_frame("f6_reen", 2'd3, 2'd3, -1);

    for (int i = 0; i < 700; i++) @(negedge pixel_clk);
    check_eq("pre_rst_blank", vout.blank, 1);
    #2 pixel_rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge pixel_clk);
    pixel_rst_n = 1'b1;
    run_frame("f7_grid", 2'd0, 2'd0, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
